seq_pattern_detector: RTL and testbench

Parametrised serial pattern detector for single-bit streams: a runtime-programmable pattern of 1..MAX_LEN bits, selectable overlapping or non-overlapping matching, an input qualifier and a saturating match counter. It is the general-purpose successor to the fixed 1001 Mealy detectors and sits directly on a serial data path. Out of reset it behaves as an overlapping 1001 detector.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_match.sv | 26 ++
 rtl/seq_pattern_detector.sv | 98 +++++++++
 tb/tb_seq_pattern_detector.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_pkg : shared defaults and mode encoding for seq detectors   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package seq_det_pkg;

  localparam int          DEF_MAX_LEN     = 8;
  localparam int          DEF_CNT_W       = 8;
  localparam int unsigned DEF_RST_PATTERN = 'b1001;
  localparam int          DEF_RST_LEN     = 4;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  localparam logic DEF_RST_OVERLAP = OVL_ON;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_match.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_det_match : masked compare of the newest len history bits      |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module seq_det_match #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic [MAX_LEN-1:0] i_hist_n,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_hit
);

  logic [MAX_LEN-1:0] w_mask;

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign w_mask[i] = (i_len > LEN_W'(i));
  end

  // A zero length must never hit, even though the empty mask compares equal.
  assign o_hit = (i_len != '0) && (((i_hist_n ^ i_pat) & w_mask) == '0);

endmodule : seq_det_match
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_pattern_detector : programmable serial pattern detector        |
// | Revision             : 1.0                                         |
// +--------------------------------------------------------------------+
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               MAX_LEN     = DEF_MAX_LEN,
  parameter int               LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int               CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int               RST_LEN     = DEF_RST_LEN,
  parameter logic             RST_OVERLAP = DEF_RST_OVERLAP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_dout;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic [LEN_W-1:0]   w_len_cap;
  logic               w_hit;
  logic               w_match;

  assign w_hist_n  = {r_hist[MAX_LEN-2:0], din};
  assign w_fill_n  = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_len_cap = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

  seq_det_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .i_hist_n (w_hist_n),
    .i_pat    (r_pat),
    .i_len    (r_len),
    .o_hit    (w_hit)
  );

  // fill guards against matching on history older than the last restart.
  assign w_match = din_valid && !cfg_load && w_hit && (w_fill_n >= r_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= RST_PATTERN;
      r_len  <= LEN_W'(RST_LEN);
      r_ovl  <= RST_OVERLAP;
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= w_len_cap;
      r_ovl  <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else if (din_valid) begin
      r_hist <= w_hist_n;
      r_dout <= w_match;
      r_fill <= (w_match && (r_ovl == OVL_OFF)) ? '0 : w_fill_n;
    end else begin
      r_dout <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign dout        = r_dout;
  assign match_count = r_cnt;

endmodule : seq_pattern_detector
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_pattern_detector : self-checking bench for the detector     |
// | Revision                : 1.0                                      |
// +--------------------------------------------------------------------+
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset, cfg_load, cfg_overlap, din_valid, din, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       dout, dout_s;
  logic [7:0] cnt;
  logic [1:0] cnt_s;

  always #5 clk = ~clk;

  seq_pattern_detector u_dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
    .din(din), .cnt_clr(cnt_clr), .dout(dout), .match_count(cnt)
  );

  seq_pattern_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
    .din(din), .cnt_clr(cnt_clr), .dout(dout_s), .match_count(cnt_s)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the accepted bits since the last restart, matched by
  // comparing the tail of that list against the pattern.
  int         m_len;
  logic [7:0] m_pat;
  bit         m_ovl;
  bit         m_bits[$];
  int         m_cnt, m_cnt_s;
  bit         m_dout;

  typedef struct {
    bit         rst, ld;
    logic [7:0] pat;
    logic [3:0] len;
    bit         ovl, v, d, clr;
    bit         e_dout;
    int         e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit hit;
    hit = 1'b0;
    if (reset) begin
      m_len = 4; m_pat = 8'b1001; m_ovl = 1'b1;
      m_bits.delete();
      m_cnt = 0; m_cnt_s = 0; m_dout = 1'b0;
    end else begin
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
        m_ovl = cfg_overlap;
        m_bits.delete();
        m_dout = 1'b0;
      end else if (din_valid) begin
        m_bits.push_back(din);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        hit = (m_len > 0) && (m_bits.size() >= m_len);
        for (int i = 0; i < m_len; i++)
          if (hit && (m_bits[m_bits.size()-1-i] != m_pat[i])) hit = 1'b0;
        m_dout = hit;
        if (hit && !m_ovl) m_bits.delete();
      end else begin
        m_dout = 1'b0;
      end
      if (cnt_clr) begin
        m_cnt = int'(hit); m_cnt_s = int'(hit);
      end else if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
      end
    end
  endtask

  task automatic step(input bit rst, input bit ld, input logic [7:0] p, input logic [3:0] l,
                      input bit ov, input bit v, input bit d, input bit clr);
    reset = rst; cfg_load = ld; cfg_pattern = p; cfg_len = l;
    cfg_overlap = ov; din_valid = v; din = d; cnt_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check("dout", dout, m_dout);
    check("dout_sat", dout_s, m_dout);
    check("count", cnt, m_cnt);
    check("count_sat", cnt_s, m_cnt_s);
  endtask

  task automatic bit_in(input bit d);
    step(0, 0, 8'h00, 4'd0, 0, 1, d, 0);
  endtask

  task automatic gap_cycle();
    step(0, 0, 8'h00, 4'd0, 0, 0, 1'($urandom_range(0, 1)), 0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit ov);
    step(0, 1, p, l, ov, 0, 0, 0);
  endtask

  function automatic vec_t mk(input bit rst, input bit ld, input logic [7:0] p, input logic [3:0] l,
                              input bit ov, input bit v, input bit d, input bit clr,
                              input bit ed, input int ec);
    vec_t t;
    t.rst = rst; t.ld = ld; t.pat = p; t.len = l; t.ovl = ov;
    t.v = v; t.d = d; t.clr = clr; t.e_dout = ed; t.e_cnt = ec;
    return t;
  endfunction

  function automatic vec_t tb_bit(input bit d, input bit ed, input int ec);
    return mk(0, 0, 8'h00, 4'd0, 0, 1, d, 0, ed, ec);
  endfunction

  int pulses, first;

  task automatic ones_run(input logic [3:0] l, input string tag);
    load(8'hFF, l, 1);
    pulses = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      bit_in(1'b1);
      if (dout) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check({tag, "_first"}, first, 8);
    check({tag, "_pulses"}, pulses, 5);
  endtask

  initial begin
    // Reset defaults then 1001001.
    tbl.push_back(mk(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(tb_bit(1, 0, 0)); tbl.push_back(tb_bit(0, 0, 0));
    tbl.push_back(tb_bit(0, 0, 0)); tbl.push_back(tb_bit(1, 1, 1));
    tbl.push_back(tb_bit(0, 0, 1)); tbl.push_back(tb_bit(0, 0, 1));
    tbl.push_back(tb_bit(1, 1, 2));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 2));
    // 101 non-overlap over 10101.
    tbl.push_back(mk(0, 1, 8'b101, 4'd3, 0, 0, 0, 0, 0, 2));
    tbl.push_back(tb_bit(1, 0, 2)); tbl.push_back(tb_bit(0, 0, 2));
    tbl.push_back(tb_bit(1, 1, 3)); tbl.push_back(tb_bit(0, 0, 3));
    tbl.push_back(tb_bit(1, 0, 3));
    // 101 overlap over 10101.
    tbl.push_back(mk(0, 1, 8'b101, 4'd3, 1, 0, 0, 0, 0, 3));
    tbl.push_back(tb_bit(1, 0, 3)); tbl.push_back(tb_bit(0, 0, 3));
    tbl.push_back(tb_bit(1, 1, 4)); tbl.push_back(tb_bit(0, 0, 4));
    tbl.push_back(tb_bit(1, 1, 5));
    tbl.push_back(mk(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 0));

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].ld, tbl[k].pat, tbl[k].len, tbl[k].ovl,
           tbl[k].v, tbl[k].d, tbl[k].clr);
      check($sformatf("tbl%0d_dout", k), dout, tbl[k].e_dout);
      check($sformatf("tbl%0d_cnt", k), cnt, tbl[k].e_cnt);
    end

    // Invalid cycles between 1,0,0,1 carry random din and must be ignored.
    load(8'b1001, 4'd4, 1);
    pulses = 0;
    bit_in(1);
    for (int g = 0; g < 3; g++) begin
      gap_cycle(); if (dout) pulses++;
    end
    bit_in(0); if (dout) pulses++;
    for (int g = 0; g < 3; g++) begin
      gap_cycle(); if (dout) pulses++;
    end
    bit_in(0); if (dout) pulses++;
    for (int g = 0; g < 3; g++) begin
      gap_cycle(); if (dout) pulses++;
    end
    bit_in(1);
    check("gap_last_dout", dout, 1);
    check("gap_pulses_before", pulses, 0);

    ones_run(4'd8, "len_max");
    ones_run(4'd11, "len_clamp");

    load(8'hFF, 4'd0, 1);
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      bit_in((k < 10) ? 1'b1 : 1'($urandom_range(0, 1)));
      if (dout) pulses++;
    end
    check("len0_pulses", pulses, 0);

    // Saturation on the 2-bit counter, then clear coincident with a match.
    step(0, 0, 8'h00, 4'd0, 0, 0, 0, 1);
    load(8'b11, 4'd2, 1);
    for (int k = 0; k < 6; k++) bit_in(1'b1);
    check("sat_cnt2", cnt_s, 3);
    check("sat_cnt8", cnt, 5);
    step(0, 0, 8'h00, 4'd0, 0, 1, 1, 1);
    check("clr_hit_cnt8", cnt, 1);
    check("clr_hit_cnt2", cnt_s, 1);

    // Reset after a partial 100 must forget it.
    step(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
    bit_in(1); bit_in(0); bit_in(0);
    step(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
    pulses = 0;
    bit_in(1); if (dout) pulses++;
    bit_in(0); if (dout) pulses++;
    bit_in(0); if (dout) pulses++;
    bit_in(1); if (dout) pulses++;
    check("rst_mid_pulses", pulses, 1);
    check("rst_mid_last", dout, 1);

    // cfg_load mid-pattern, with a valid din on the load cycle discarded.
    bit_in(1); bit_in(0); bit_in(0);
    step(0, 1, 8'b1001, 4'd4, 1, 1, 1, 0);
    pulses = 0;
    bit_in(1); if (dout) pulses++;
    bit_in(0); if (dout) pulses++;
    bit_in(0); if (dout) pulses++;
    bit_in(1); if (dout) pulses++;
    check("ld_mid_pulses", pulses, 1);
    check("ld_mid_last", dout, 1);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int         r;
      logic [3:0] l;
      r = int'($urandom_range(0, 999));
      l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(1, 4));
      step(r < 3, (r >= 3) && (r < 30), 8'($urandom), l, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_seq_pattern_detector
`default_nettype wire
